// File: rtl/multiplicador_reconstructor_pkg.sv
// Shared types and helpers for the signed divider / reconstructor family.
// Holds the FSM state encoding, counter sizing and the two's-complement abs helper.
package multiplicador_reconstructor_pkg;

    localparam int TAMANYO_DEF = 32;
    // Widest operand the abs helper handles; callers zero-extend into it.
    localparam int ABS_W       = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        FIX  = 2'd2
    } estado_t;

    function automatic int cnt_width(input int t);
        return $clog2(t + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(TAMANYO_DEF);

    // Magnitude of the w-bit two's-complement value in x[w-1:0]; the most
    // negative value maps to 2^(w-1) as an unsigned number.
    function automatic logic [ABS_W-1:0] abs_c2(input logic [ABS_W-1:0] x,
                                               input int unsigned      w);
        logic [ABS_W-1:0] mask;
        logic             neg;
        mask = (ABS_W'(1) << w) - ABS_W'(1);
        neg  = |(x & (ABS_W'(1) << (w - 1)));
        if (neg) begin
            return (~x + ABS_W'(1)) & mask;
        end
        return x & mask;
    endfunction

endpackage

// File: rtl/multiplicador_reconstructor.sv
// Sequential signed multiply-add Num = Coc*Den + Res (inverse of the signed dividers).
// Latency: tamanyo+1 edges from Start acceptance to Done; one result per tamanyo+2 cycles.
// Backpressure: none; Start is only sampled in IDLE and ignored while Busy.
module multiplicador_reconstructor
    import multiplicador_reconstructor_pkg::*;
#(
    parameter int tamanyo = TAMANYO_DEF
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic [tamanyo-1:0] Coc,
    input  logic [tamanyo-1:0] Den,
    input  logic [tamanyo-1:0] Res,
    output logic [tamanyo-1:0] Num,
    output logic               Ovf,
    output logic               Busy,
    output logic               Done
);

    localparam int CNT_W = cnt_width(tamanyo);
    localparam int AW    = 2 * tamanyo;

    estado_t state, state_n;

    logic             load, iter, fix;
    logic [tamanyo-1:0] mcand;
    logic [tamanyo-1:0] mplier;
    logic [tamanyo-1:0] res_q;
    logic             sgn;
    logic [AW-1:0]    acc;
    logic [CNT_W-1:0] cnt;

    logic [tamanyo:0]   sum_hi;
    logic [AW-1:0]      p_fix;
    logic [AW-1:0]      s_fix;
    logic [tamanyo:0]   s_top;
    logic               ovf_n;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        iter    = 1'b0;
        fix     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load    = 1'b1;
                    state_n = MULT;
                end
            end
            MULT: begin
                iter = 1'b1;
                if (cnt == CNT_W'(tamanyo - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                fix     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Carry out of the upper half is kept and shifted into the accumulator MSB.
    always_comb begin
        sum_hi = {1'b0, acc[AW-1:tamanyo]} + (mplier[0] ? {1'b0, mcand} : '0);
        p_fix  = sgn ? (~acc + AW'(1)) : acc;
        s_fix  = p_fix + {{tamanyo{res_q[tamanyo-1]}}, res_q};
        s_top  = s_fix[AW-1:tamanyo-1];
        ovf_n  = !((&s_top) || !(|s_top));
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            mcand  <= '0;
            mplier <= '0;
            res_q  <= '0;
            sgn    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= tamanyo'(abs_c2(ABS_W'(Coc), tamanyo));
            mplier <= tamanyo'(abs_c2(ABS_W'(Den), tamanyo));
            res_q  <= Res;
            sgn    <= Coc[tamanyo-1] ^ Den[tamanyo-1];
            acc    <= '0;
            cnt    <= '0;
        end else if (iter) begin
            acc    <= {sum_hi, acc[tamanyo-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            Num  <= '0;
            Ovf  <= 1'b0;
            Done <= 1'b0;
        end else begin
            Done <= fix;
            if (fix) begin
                Num <= s_fix[tamanyo-1:0];
                Ovf <= ovf_n;
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_multiplicador_reconstructor.sv
// Directed bench for multiplicador_reconstructor at tamanyo=32.
module tb_multiplicador_reconstructor;

    localparam int T = 32;

    logic         CLK;
    logic         RSTa;
    logic         Start;
    logic [T-1:0] Coc;
    logic [T-1:0] Den;
    logic [T-1:0] Res;
    logic [T-1:0] Num;
    logic         Ovf;
    logic         Busy;
    logic         Done;

    int checks;
    int errors;

    multiplicador_reconstructor #(.tamanyo(T)) dut (
        .CLK   (CLK),
        .RSTa  (RSTa),
        .Start (Start),
        .Coc   (Coc),
        .Den   (Den),
        .Res   (Res),
        .Num   (Num),
        .Ovf   (Ovf),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse Start for one edge, scramble operands after acceptance, wait for Done.
    task automatic do_op(input logic [T-1:0] c, input logic [T-1:0] d,
                         input logic [T-1:0] r, output int lat, output int busy_n);
        Coc   = c;
        Den   = d;
        Res   = r;
        Start = 1'b1;
        @(posedge CLK); #1;
        Start  = 1'b0;
        Coc    = ~c;
        Den    = d ^ 32'h5A5A_0F0F;
        Res    = ~r;
        lat    = 0;
        busy_n = Busy ? 1 : 0;
        while (!Done && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
            if (Busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        RSTa  = 1'b0;
        Start = 1'b0;
        Coc   = '0;
        Den   = '0;
        Res   = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (Num !== 32'h0 || Ovf !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: Num=%h Ovf=%b Busy=%b Done=%b, want all 0", Num, Ovf, Busy, Done);
        end
        @(negedge CLK);
        RSTa = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        int lat, bn;
        do_op(32'd7, 32'd3, 32'd2, lat, bn);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, want 33", lat);
        end
        checks++;
        if (Num !== 32'd23 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: Num=%h Ovf=%b, want 00000017/0", Num, Ovf);
        end
        checks++;
        if (bn !== 33) begin
            errors++;
            $display("FAIL basic_busy: Busy high %0d cycles, want 33", bn);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_falls_with_done: Busy=%b, want 0", Busy);
        end
    endtask

    task automatic test_signs();
        int lat, bn;
        do_op(32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFE, lat, bn);
        checks++;
        if (Num !== 32'hFFFF_FFE9 || Ovf !== 1'b0 || lat !== 33) begin
            errors++;
            $display("FAIL neg_coc: Num=%h Ovf=%b lat=%0d, want FFFFFFE9/0/33", Num, Ovf, lat);
        end
        do_op(32'd7, 32'hFFFF_FFFD, 32'd2, lat, bn);
        checks++;
        if (Num !== 32'hFFFF_FFED || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL neg_den: Num=%h Ovf=%b, want FFFFFFED/0", Num, Ovf);
        end
    endtask

    task automatic test_boundary();
        int lat, bn;
        do_op(32'h8000_0000, 32'd1, 32'd0, lat, bn);
        checks++;
        if (Num !== 32'h8000_0000 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL min_times_one: Num=%h Ovf=%b, want 80000000/0", Num, Ovf);
        end
        do_op(32'h0001_0000, 32'h0001_0000, 32'd0, lat, bn);
        checks++;
        if (Num !== 32'h0 || Ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_2pow32: Num=%h Ovf=%b, want 00000000/1", Num, Ovf);
        end
        do_op(32'd5, 32'd0, 32'hFFFF_FFF7, lat, bn);
        checks++;
        if (Num !== 32'hFFFF_FFF7 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL den_zero: Num=%h Ovf=%b, want FFFFFFF7/0", Num, Ovf);
        end
        do_op(32'h8000_0000, 32'h8000_0000, 32'd0, lat, bn);
        checks++;
        if (Num !== 32'h0 || Ovf !== 1'b1) begin
            errors++;
            $display("FAIL min_times_min: Num=%h Ovf=%b, want 00000000/1", Num, Ovf);
        end
        // 1 + 0x7FFFFFFF overflows only through the addend.
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, lat, bn);
        checks++;
        if (Num !== 32'h8000_0000 || Ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_by_addend: Num=%h Ovf=%b, want 80000000/1", Num, Ovf);
        end
    endtask

    task automatic test_back_to_back();
        int nd, d1, d2, wait_n;
        logic [T-1:0] n1, n2;
        nd = 0; d1 = -1; d2 = -1; n1 = '0; n2 = '0;
        Coc = 32'd7; Den = 32'd3; Res = 32'd2; Start = 1'b1;
        @(posedge CLK); #1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge CLK); #1;
            if (Done) begin
                nd++;
                if (nd == 1) begin d1 = i; n1 = Num; end
                else if (nd == 2) begin d2 = i; n2 = Num; end
            end
            if (i == 5)  begin Coc = 32'h0000_1234; Den = 32'hFFFF_0000; Res = 32'h55; end
            if (i == 30) begin Coc = 32'd7; Den = 32'd3; Res = 32'd2; end
        end
        Start = 1'b0;
        checks++;
        if (nd !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d pulses, want 2", nd);
        end
        checks++;
        if (d1 !== 33 || d2 !== 67) begin
            errors++;
            $display("FAIL b2b_done_cycles: got %0d,%0d, want 33,67", d1, d2);
        end
        checks++;
        if (n1 !== 32'd23 || n2 !== 32'd23) begin
            errors++;
            $display("FAIL b2b_results: got %h,%h, want 00000017 twice", n1, n2);
        end
        wait_n = 0;
        while (!Done && wait_n < 40) begin
            @(posedge CLK); #1;
            wait_n++;
        end
        checks++;
        if (!Done) begin
            errors++;
            $display("FAIL b2b_drain: no Done within 40 cycles, want one");
        end
    endtask

    task automatic test_reset_midop();
        int lat, bn, nd;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, lat, bn);
        Coc = 32'd7; Den = 32'd3; Res = 32'd2; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        RSTa = 1'b0;
        #1;
        checks++;
        if (Num !== 32'h0 || Ovf !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: Num=%h Ovf=%b Busy=%b Done=%b, want all 0", Num, Ovf, Busy, Done);
        end
        @(negedge CLK);
        RSTa = 1'b1;
        nd = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            if (Done || Busy) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL reset_discard: %0d cycles with Done/Busy, want 0", nd);
        end
        do_op(32'd7, 32'd3, 32'd2, lat, bn);
        checks++;
        if (Num !== 32'd23 || Ovf !== 1'b0 || lat !== 33) begin
            errors++;
            $display("FAIL after_reset: Num=%h Ovf=%b lat=%0d, want 00000017/0/33", Num, Ovf, lat);
        end
    endtask

    // Quotient/remainder pairs from truncating signed division must rebuild the dividend.
    task automatic test_divider_vectors();
        int num, den, q, r, lat, bn;
        for (int i = 0; i < 1000; i++) begin
            num = int'($urandom);
            den = int'($urandom);
            if (i % 4 == 1) den = den >>> 20;
            if (i % 50 == 0) den = 1;
            if (i % 50 == 1) den = -1;
            if (i % 50 == 2 || i % 50 == 0) num = 32'sh8000_0000;
            if (i % 50 == 3) num = 0;
            if (den == 0) den = 7;
            if (num == 32'sh8000_0000 && den == -1) den = 3;
            q = num / den;
            r = num % den;
            do_op(q, den, r, lat, bn);
            checks++;
            if (Num !== num || Ovf !== 1'b0 || lat !== 33) begin
                errors++;
                $display("FAIL divider_roundtrip[%0d]: Coc=%h Den=%h Res=%h -> Num=%h Ovf=%b lat=%0d, want %h/0/33",
                         i, q, den, r, Num, Ovf, lat, num);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_signs();
        test_boundary();
        test_back_to_back();
        test_reset_midop();
        test_divider_vectors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
